lab2_proc_iter_muldiv: RTL



---
 rtl/lab2_proc_muldiv_pkg.sv | 20 ++
 rtl/lab2_proc_iter_muldiv_dpath.sv | 83 ++++++++
 rtl/lab2_proc_iter_muldiv.sv | 79 +++++++
 3 files changed

// File: rtl/lab2_proc_muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: function codes,
// FSM states and the request message layout.
package lab2_proc_muldiv_pkg;

    localparam int DATA_W = 32;
    localparam int FN_W   = 3;
    localparam int MSG_W  = FN_W + 2 * DATA_W;
    localparam int FN_LSB = 2 * DATA_W;
    localparam int A_LSB  = DATA_W;
    localparam int B_LSB  = 0;

    localparam logic [FN_W-1:0] MULDIV_MUL  = 3'd0;
    localparam logic [FN_W-1:0] MULDIV_DIV  = 3'd1;
    localparam logic [FN_W-1:0] MULDIV_DIVU = 3'd2;
    localparam logic [FN_W-1:0] MULDIV_REM  = 3'd3;
    localparam logic [FN_W-1:0] MULDIV_REMU = 3'd4;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

endpackage

// File: rtl/lab2_proc_iter_muldiv_dpath.sv
// Datapath for the iterative mul/div: shift-add multiply, restoring divide on
// magnitudes, sign fixup and result select.
module lab2_proc_iter_muldiv_dpath
    import lab2_proc_muldiv_pkg::*;
#(
    parameter int NBITS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             calc,
    input  logic [FN_W-1:0]  fn_in,
    input  logic [NBITS-1:0] a_in,
    input  logic [NBITS-1:0] b_in,
    output logic [NBITS-1:0] result
);

    logic [FN_W-1:0]  fn_r;
    logic [NBITS-1:0] op_a;   // multiplicand, or dividend shifting into quotient
    logic [NBITS-1:0] op_b;   // multiplier, or divisor magnitude
    logic [NBITS-1:0] acc;
    logic [NBITS-1:0] rem;
    logic             neg_q;
    logic             neg_r;

    logic             signed_in;
    logic [NBITS:0]   rem_sh;
    logic [NBITS:0]   sub;
    logic             fits;

    assign signed_in = (fn_in == MULDIV_DIV) || (fn_in == MULDIV_REM);

    always_comb begin
        rem_sh = {rem, op_a[NBITS-1]};
        sub    = rem_sh - {1'b0, op_b};
        fits   = rem_sh >= {1'b0, op_b};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fn_r  <= '0;
            op_a  <= '0;
            op_b  <= '0;
            acc   <= '0;
            rem   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (load) begin
            fn_r  <= fn_in;
            op_a  <= (signed_in && a_in[NBITS-1]) ? -a_in : a_in;
            op_b  <= (signed_in && b_in[NBITS-1]) ? -b_in : b_in;
            acc   <= '0;
            rem   <= '0;
            neg_q <= signed_in && (a_in[NBITS-1] ^ b_in[NBITS-1]);
            neg_r <= signed_in && a_in[NBITS-1];
        end else if (calc) begin
            if (fn_r == MULDIV_MUL) begin
                if (op_b[0])
                    acc <= acc + op_a;
                op_a <= op_a << 1;
                op_b <= op_b >> 1;
            end else begin
                rem  <= fits ? sub[NBITS-1:0] : rem_sh[NBITS-1:0];
                op_a <= {op_a[NBITS-2:0], fits};
            end
        end
    end

    // Divide by zero leaves quot=all-ones and rem=|a| naturally; only signed
    // DIV needs forcing, since the sign fixup would otherwise negate it.
    always_comb begin
        result = '0;
        case (fn_r)
            MULDIV_MUL:  result = acc;
            MULDIV_DIV:  result = (op_b == '0) ? '1 : (neg_q ? -op_a : op_a);
            MULDIV_DIVU: result = op_a;
            MULDIV_REM:  result = neg_r ? -rem : rem;
            MULDIV_REMU: result = rem;
            default:     result = '0;
        endcase
    end

endmodule

// File: rtl/lab2_proc_iter_muldiv.sv
// Iterative 32-cycle multiply/divide unit with val/rdy request/response
// streams; holds the FSM, iteration counter and handshake logic.
module lab2_proc_iter_muldiv
    import lab2_proc_muldiv_pkg::*;
#(
    parameter int NBITS = 32,
    parameter int NITER = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             istream_val,
    output logic             istream_rdy,
    input  logic [MSG_W-1:0] istream_msg,
    output logic             ostream_val,
    input  logic             ostream_rdy,
    output logic [NBITS-1:0] ostream_msg
);

    localparam int CW = $clog2(NITER + 1);

    state_t        state_r;
    state_t        state_n;
    logic [CW-1:0] cnt_r;
    logic          load;
    logic          calc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_n;
            if (load)
                cnt_r <= CW'(NITER);
            else if (calc)
                cnt_r <= cnt_r - CW'(1);
        end
    end

    always_comb begin
        state_n     = state_r;
        istream_rdy = 1'b0;
        ostream_val = 1'b0;
        load        = 1'b0;
        calc        = 1'b0;
        case (state_r)
            IDLE: begin
                istream_rdy = 1'b1;
                if (istream_val) begin
                    load    = 1'b1;
                    state_n = CALC;
                end
            end
            CALC: begin
                calc = 1'b1;
                if (cnt_r == CW'(1))
                    state_n = DONE;
            end
            DONE: begin
                ostream_val = 1'b1;
                if (ostream_rdy)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    lab2_proc_iter_muldiv_dpath #(.NBITS(NBITS)) u_dpath (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .calc   (calc),
        .fn_in  (istream_msg[FN_LSB +: FN_W]),
        .a_in   (istream_msg[A_LSB +: NBITS]),
        .b_in   (istream_msg[B_LSB +: NBITS]),
        .result (ostream_msg)
    );

endmodule
